// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file write-back scheduler: width defaults and
// the round-robin arbiter state encoding.
package regfile_wb_scheduler_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        PrioA = 1'b0,
        PrioB = 1'b1
    } prio_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational on requests and state;
// the favoured requester flips to the other one after every grant.
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    prio_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PrioA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        if (req_a && (!req_b || state_q == PrioA)) begin
            gnt_a   = 1'b1;
            state_d = PrioB;
        end else if (req_b) begin
            gnt_b   = 1'b1;
            state_d = PrioA;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates two producers onto the single register-file write
// port and tracks pending destinations so issue can detect RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] src_one,
    input  logic [ADDR_W-1:0] src_two,
    output logic              src_one_busy,
    output logic              src_two_busy,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data_in
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0] busy_q, busy_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (a_ready),
        .gnt_b (b_ready)
    );

    assign rsv_ready    = !busy_q[rsv_rd] || (rsv_rd == '0);
    assign src_one_busy = busy_q[src_one];
    assign src_two_busy = busy_q[src_two];

    assign sel_rd   = a_ready ? a_rd : b_rd;
    assign sel_data = a_ready ? a_data : b_data;

    // Grants to x0 still complete the handshake but never reach the register file.
    always_comb begin
        we_d   = (a_ready || b_ready) && (sel_rd != '0);
        dest_d = dest_q;
        data_d = data_q;
        if (we_d) begin
            dest_d = sel_rd;
            data_d = sel_data;
        end
    end

    // A busy reservation blocks rsv_ready, so clear and set never collide on one index.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[dest_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign write_enable = we_q;
    assign dest         = dest_q;
    assign data_in      = data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: expected register-file writes are queued at handshake time and a
// negedge monitor pops and compares each write the DUT presents.
module tb_regfile_wb_scheduler;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rsv_valid;
    logic [AW-1:0] rsv_rd;
    logic          rsv_ready;
    logic [AW-1:0] src_one, src_two;
    logic          src_one_busy, src_two_busy;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_rd, b_rd;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          write_enable;
    logic [AW-1:0] dest;
    logic [DW-1:0] data_in;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rsv_valid    (rsv_valid),
        .rsv_rd       (rsv_rd),
        .rsv_ready    (rsv_ready),
        .src_one      (src_one),
        .src_two      (src_two),
        .src_one_busy (src_one_busy),
        .src_two_busy (src_two_busy),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .write_enable (write_enable),
        .dest         (dest),
        .data_in      (data_in)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        if (write_enable) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got dest=%0d data=0x%0h, expected none",
                         dest, data_in);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_dest", 64'(dest), 64'(e[AW+DW-1:DW]));
                chk("wr_data", 64'(data_in), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        rsv_valid = 1'b0; rsv_rd = '0; src_one = '0; src_two = '0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;

        // Reset and idle.
        do_reset();
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_dest", 64'(dest), 64'd0);
        chk("rst_data", 64'(data_in), 64'd0);
        for (int r = 0; r < 32; r += 5) begin
            rsv_rd = AW'(r); src_one = AW'(r); src_two = AW'(31 - r);
            #1;
            chk("rst_rsv_ready", 64'(rsv_ready), 64'd1);
            chk("rst_src1_busy", 64'(src_one_busy), 64'd0);
            chk("rst_src2_busy", 64'(src_two_busy), 64'd0);
        end

        // Reserve x5, then A writes it.
        rsv_valid = 1'b1; rsv_rd = 5'd5;
        #1 chk("rsv5_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 1'b0; src_one = 5'd5; src_two = 5'd5;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        chk("x5_busy", 64'(src_one_busy), 64'd1);
        chk("x5_busy_src2", 64'(src_two_busy), 64'd1);
        chk("a_ready_x5", 64'(a_ready), 64'd1);
        chk("b_ready_x5", 64'(b_ready), 64'd0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        a_valid = 1'b0;
        #1;
        chk("x5_we", 64'(write_enable), 64'd1);
        chk("x5_busy_during_wr", 64'(src_one_busy), 64'd1);
        tick();
        chk("x5_busy_after_wr", 64'(src_one_busy), 64'd0);
        chk("x5_we_idle", 64'(write_enable), 64'd0);

        // Both producers valid from reset: grants alternate A,B,A,B.
        do_reset();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", 64'(a_ready), 64'((i % 2) == 0));
            chk("rr_b_ready", 64'(b_ready), 64'((i % 2) == 1));
            if ((i % 2) == 0) exp_q.push_back({5'd1, 32'h11});
            else exp_q.push_back({5'd2, 32'h22});
            if (i > 0) chk("rr_we_cont", 64'(write_enable), 64'd1);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1 chk("rr_we_last", 64'(write_enable), 64'd1);
        tick();

        // WAW stall on x7 until B writes it.
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        #1 chk("rsv7_first", 64'(rsv_ready), 64'd1);
        tick();
        #1 chk("rsv7_second", 64'(rsv_ready), 64'd0);
        tick();
        rsv_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        #1 chk("b_ready_x7", 64'(b_ready), 64'd1);
        exp_q.push_back({5'd7, 32'h77});
        tick();
        b_valid = 1'b0;
        #1 chk("rsv7_during_wr", 64'(rsv_ready), 64'd0);
        tick();
        chk("rsv7_after_wr", 64'(rsv_ready), 64'd1);

        // x0: handshake but no write, never busy.
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF;
        #1 chk("a_ready_x0", 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
        #1 chk("x0_we", 64'(write_enable), 64'd0);
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        #1 chk("rsv0_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 1'b0; src_one = 5'd0; src_two = 5'd0;
        #1;
        chk("x0_busy", 64'(src_one_busy), 64'd0);
        chk("x0_busy_src2", 64'(src_two_busy), 64'd0);

        // Reset drops a captured B write to x9 and clears its reservation.
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0; src_one = 5'd9;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        #1;
        chk("x9_busy", 64'(src_one_busy), 64'd1);
        chk("b_ready_x9", 64'(b_ready), 64'd1);
        rst = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("x9_dropped_we", 64'(write_enable), 64'd0);
        chk("x9_busy_cleared", 64'(src_one_busy), 64'd0);
        a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd3; b_rd = 5'd4;
        #1;
        chk("post_rst_a_ready", 64'(a_ready), 64'd1);
        chk("post_rst_b_ready", 64'(b_ready), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
